// File: rtl/nios_ii_adc_pkg.sv
// nios_ii_adc_pkg: register map, bit positions and ID constant for the ADC capture slave
package nios_ii_adc_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;
    localparam logic [1:0] ADDR_ID      = 2'd3;

    localparam int DATA_VALID_BIT = 31;
    localparam int DATA_CH_LSB    = 16;

    localparam int ST_EMPTY  = 16;
    localparam int ST_FULL   = 17;
    localparam int ST_OVF    = 18;
    localparam int ST_BAD_CH = 19;

    localparam int CTL_EN      = 0;
    localparam int CTL_IRQ_EN  = 1;
    localparam int CTL_FLUSH   = 2;
    localparam int CTL_THR_LSB = 8;

    localparam logic [15:0] ID_MAGIC = 16'h0ADC;

    localparam logic [7:0] THR_RESET = 8'd1;

endpackage

// File: rtl/adc_sample_fifo.sv
// adc_sample_fifo: synchronous FIFO with wrap-bit pointers, combinational head and flush
module adc_sample_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 16,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    logic [W-1:0]     mem [DEPTH];
    logic [LVL_W-1:0] wr_ptr;
    logic [LVL_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // a full FIFO still takes a push when a pop frees a slot in the same cycle
    assign do_push = push & (~full | pop) & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    assign level = wr_ptr - rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[LVL_W-1] != rd_ptr[LVL_W-1]) &&
                   (wr_ptr[LVL_W-2:0] == rd_ptr[LVL_W-2:0]);
    assign dout  = mem[rd_ptr[LVL_W-2:0]];

    // pointer update; flush collapses both pointers so the FIFO is empty next cycle
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // storage is not reset; only the pointers define what is valid
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[LVL_W-2:0]] <= din;
    end

endmodule

// File: rtl/nios_ii_adc_capture.sv
// nios_ii_adc_capture: Avalon-MM slave buffering tagged ADC samples with a level/overflow irq
module nios_ii_adc_capture
    import nios_ii_adc_pkg::*;
#(
    parameter int DATA_W     = 12,
    parameter int N_CH       = 4,
    parameter int FIFO_DEPTH = 16,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq
);

    localparam logic [CH_W:0] N_CH_V = N_CH[CH_W:0];

    logic                   enable;
    logic                   irq_en;
    logic [7:0]             threshold;
    logic                   overflow;
    logic                   bad_ch;
    logic                   ch_ok;
    logic                   push_req;
    logic                   pop;
    logic                   flush;
    logic                   wr_status;
    logic                   wr_control;
    logic                   ovf_set;
    logic                   bad_set;
    logic                   irq_next;
    logic [DATA_W+CH_W-1:0] head;
    logic [LVL_W-1:0]       level;
    logic                   full;
    logic                   empty;
    logic [31:0]            rd_mux;

    assign ch_ok      = {1'b0, in_ch} < N_CH_V;
    assign push_req   = in_valid & enable & ch_ok;
    assign pop        = chipselect & read & (address == ADDR_DATA) & ~empty;
    assign wr_status  = chipselect & write & (address == ADDR_STATUS);
    assign wr_control = chipselect & write & (address == ADDR_CONTROL);
    assign flush      = wr_control & writedata[CTL_FLUSH];
    assign ovf_set    = push_req & full & ~pop & ~flush;
    assign bad_set    = in_valid & enable & ~ch_ok;

    adc_sample_fifo #(
        .W     (DATA_W + CH_W),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (pop),
        .flush (flush),
        .din   ({in_ch, in_data}),
        .dout  (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    // control register; flush is a strobe and is never stored
    always_ff @(posedge clk) begin
        if (reset) begin
            enable    <= 1'b0;
            irq_en    <= 1'b0;
            threshold <= THR_RESET;
        end else if (wr_control) begin
            enable    <= writedata[CTL_EN];
            irq_en    <= writedata[CTL_IRQ_EN];
            threshold <= writedata[CTL_THR_LSB +: 8];
        end
    end

    // sticky flags; a same-cycle set event beats write-1-to-clear
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            bad_ch   <= 1'b0;
        end else begin
            overflow <= ovf_set | (overflow & ~(wr_status & writedata[ST_OVF]));
            bad_ch   <= bad_set | (bad_ch & ~(wr_status & writedata[ST_BAD_CH]));
        end
    end

    // read mux and irq condition, evaluated from current registered state
    always_comb begin
        rd_mux   = '0;
        irq_next = irq_en & (((16'(level) >= 16'(threshold)) & (threshold != 8'd0)) | overflow);
        if (address == ADDR_DATA && !empty) begin
            rd_mux[15:0]                       = 16'(head[DATA_W-1:0]);
            rd_mux[DATA_CH_LSB +: 8]           = 8'(head[DATA_W +: CH_W]);
            rd_mux[DATA_VALID_BIT]             = 1'b1;
        end else if (address == ADDR_STATUS) begin
            rd_mux[LVL_W-1:0]                  = level;
            rd_mux[ST_EMPTY]                   = empty;
            rd_mux[ST_FULL]                    = full;
            rd_mux[ST_OVF]                     = overflow;
            rd_mux[ST_BAD_CH]                  = bad_ch;
        end else if (address == ADDR_CONTROL) begin
            rd_mux[CTL_EN]                     = enable;
            rd_mux[CTL_IRQ_EN]                 = irq_en;
            rd_mux[CTL_THR_LSB +: 8]           = threshold;
        end else if (address == ADDR_ID) begin
            rd_mux = {8'(N_CH - 1), 8'(DATA_W), ID_MAGIC};
        end
    end

    // registered bus output and interrupt; the pop advances at the same edge readdata captures the head
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            readdata <= rd_mux;
            irq      <= irq_next;
        end
    end

endmodule

// File: tb/tb_nios_ii_adc_capture.sv
// tb_nios_ii_adc_capture: directed self-checking bench for the ADC capture slave
module tb_nios_ii_adc_capture;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [11:0] in_data = '0;
    logic [1:0]  in_ch = '0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;

    int errors = 0;
    int checks = 0;
    logic [31:0] rv;

    nios_ii_adc_capture dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ch      (in_ch),
        .address    (address),
        .chipselect (chipselect),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write = 1'b0; writedata = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        chipselect = 1'b1; read = 1'b1; address = a;
        tick();
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic push(input logic [1:0] ch, input logic [11:0] d);
        in_valid = 1'b1; in_ch = ch; in_data = d;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        reset = 1'b0;

        bus_read(2'd3, rv);
        check("id", rv, 32'h030C0ADC);
        bus_read(2'd2, rv);
        check("control_reset", rv, 32'h00000100);
        check("irq_idle", {31'b0, irq}, 32'h0);

        bus_write(2'd2, 32'h101);
        push(2'd2, 12'hABC);
        push(2'd0, 12'h001);
        bus_read(2'd0, rv);
        check("data0", rv, 32'h80020ABC);
        bus_read(2'd0, rv);
        check("data1", rv, 32'h80000001);
        bus_read(2'd0, rv);
        check("data_empty", rv, 32'h0);
        bus_read(2'd1, rv);
        check("status_empty", rv, 32'h00010000);

        for (int i = 0; i < 17; i++) push(2'd1, 12'(i));
        bus_read(2'd1, rv);
        check("status_full_ovf", rv, 32'h00060010);
        bus_write(2'd1, 32'h40000);
        bus_read(2'd1, rv);
        check("status_ovf_cleared", rv, 32'h00020010);

        in_valid = 1'b1; in_ch = 2'd1; in_data = 12'h777;
        chipselect = 1'b1; read = 1'b1; address = 2'd0;
        tick();
        in_valid = 1'b0; chipselect = 1'b0; read = 1'b0;
        check("pushpop_head", readdata, 32'h80010000);
        bus_read(2'd1, rv);
        check("pushpop_status", rv, 32'h00020010);

        bus_write(2'd2, 32'h105);
        bus_read(2'd1, rv);
        check("flush_status", rv, 32'h00010000);
        bus_read(2'd2, rv);
        check("flush_reads_0", rv, 32'h00000101);

        bus_write(2'd2, 32'h403);
        for (int i = 0; i < 3; i++) push(2'd3, 12'(12'h100 + i));
        check("irq_lvl3", {31'b0, irq}, 32'h0);
        push(2'd3, 12'h103);
        check("irq_same_edge", {31'b0, irq}, 32'h0);
        tick();
        check("irq_rise", {31'b0, irq}, 32'h1);
        bus_read(2'd0, rv);
        check("irq_pop_data", rv, 32'h80030100);
        check("irq_hold", {31'b0, irq}, 32'h1);
        tick();
        check("irq_fall", {31'b0, irq}, 32'h0);

        bus_write(2'd2, 32'h100);
        bus_read(2'd1, rv);
        check("disable_keeps_3", rv, 32'h00000003);
        bus_write(2'd2, 32'h105);
        bus_write(2'd2, 32'h100);
        for (int i = 0; i < 3; i++) push(2'd1, 12'h055);
        bus_read(2'd1, rv);
        check("disabled_level0", rv, 32'h00010000);

        bus_write(2'd2, 32'h101);
        for (int i = 0; i < 5; i++) push(2'd2, 12'(i));
        bus_read(2'd1, rv);
        check("level5", rv, 32'h00000005);
        in_valid = 1'b1; in_ch = 2'd0; in_data = 12'hFFF;
        bus_write(2'd2, 32'h105);
        in_valid = 1'b0;
        bus_read(2'd1, rv);
        check("flush_with_push", rv, 32'h00010000);

        bus_write(2'd2, 32'h403);
        for (int i = 0; i < 5; i++) push(2'd1, 12'(i + 8));
        tick();
        check("pre_reset_irq", {31'b0, irq}, 32'h1);
        reset = 1'b1; in_valid = 1'b1; in_ch = 2'd2; in_data = 12'h321;
        chipselect = 1'b1; read = 1'b1; address = 2'd0;
        tick();
        check("midreset_readdata", readdata, 32'h0);
        check("midreset_irq", {31'b0, irq}, 32'h0);
        reset = 1'b0; in_valid = 1'b0; chipselect = 1'b0; read = 1'b0;
        bus_read(2'd1, rv);
        check("midreset_status", rv, 32'h00010000);
        bus_read(2'd2, rv);
        check("midreset_control", rv, 32'h00000100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
